// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall requests, sequences exception/ERET
// flushes and tracks stall watchdog and stall-cycle statistics.
module pipe_ctrl #(
    parameter logic [31:0] EXCP_VECTOR = 32'hBFC00380,
    parameter int          TIMEOUT     = 1024,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             excp_valid,
    input  logic             eret_valid,
    input  logic [31:0]      epc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          flush_q;
    logic          take;
    logic [5:0]    stall_req;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        stall_req = 6'b000000;
        if (stallreq_mem)
            stall_req = 6'b011111;
        else if (stallreq_ex)
            stall_req = 6'b001111;
        else if (stallreq_id)
            stall_req = 6'b000111;
        else if (stallreq_if)
            stall_req = 6'b000011;
    end

    always_comb begin
        stall     = 6'b000000;
        take      = 1'b0;
        state_nxt = state;
        case (state)
            RUN: begin
                stall = stall_req;
                take  = (excp_valid | eret_valid) & ~stallreq_mem;
                if (take)
                    state_nxt = FLUSH;
            end
            FLUSH: state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
        if (rst) begin
            stall = 6'b000000;
        end
    end

    always_comb begin
        cnt_nxt = stall_cnt;
        if (stall == 6'b000000)
            cnt_nxt = '0;
        else if (stall_cnt != TMO)
            cnt_nxt = stall_cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            flush_q       <= 1'b0;
            new_pc        <= 32'h0;
            stall_cnt     <= '0;
            stall_timeout <= 1'b0;
            stall_cycles  <= '0;
        end else begin
            state     <= state_nxt;
            flush_q   <= take;
            stall_cnt <= cnt_nxt;
            if (take)
                new_pc <= excp_valid ? EXCP_VECTOR : epc;
            if (cnt_nxt == TMO)
                stall_timeout <= 1'b1;
            if (stall != 6'b000000)
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    // reset kills a pending flush within the same cycle
    assign flush = flush_q & ~rst;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        excp_valid, eret_valid;
    logic [31:0] epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        tmo;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];

    localparam logic [31:0] EV = 32'hBFC00380;
    localparam logic [31:0] RA = 32'h80000100;

    pipe_ctrl #(
        .EXCP_VECTOR(EV),
        .TIMEOUT(4),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stallreq_if(stallreq_if),
        .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex),
        .stallreq_mem(stallreq_mem),
        .excp_valid(excp_valid),
        .eret_valid(eret_valid),
        .epc(epc),
        .stall(stall),
        .flush(flush),
        .new_pc(new_pc),
        .stall_timeout(stall_timeout),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // req = {mem, ex, id, if}
    task automatic cyc(
        input string       name,
        input logic        r,
        input logic [3:0]  req,
        input logic        ex,
        input logic        er,
        input logic [31:0] pc_in,
        input logic [5:0]  e_stall,
        input logic        e_flush,
        input logic [31:0] e_pc,
        input logic        e_tmo,
        input logic [31:0] e_cyc
    );
        exp_t e;
        rst          = r;
        stallreq_mem = req[3];
        stallreq_ex  = req[2];
        stallreq_id  = req[1];
        stallreq_if  = req[0];
        excp_valid   = ex;
        eret_valid   = er;
        epc          = pc_in;
        e.name   = name;
        e.stall  = e_stall;
        e.flush  = e_flush;
        e.new_pc = e_pc;
        e.tmo    = e_tmo;
        e.cyc    = e_cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks += 5;
            if (stall !== e.stall) begin
                errors++;
                $display("FAIL %s stall: got %b want %b", e.name, stall, e.stall);
            end
            if (flush !== e.flush) begin
                errors++;
                $display("FAIL %s flush: got %b want %b", e.name, flush, e.flush);
            end
            if (new_pc !== e.new_pc) begin
                errors++;
                $display("FAIL %s new_pc: got %h want %h", e.name, new_pc, e.new_pc);
            end
            if (stall_timeout !== e.tmo) begin
                errors++;
                $display("FAIL %s timeout: got %b want %b", e.name, stall_timeout, e.tmo);
            end
            if (stall_cycles !== e.cyc) begin
                errors++;
                $display("FAIL %s cycles: got %0d want %0d", e.name, stall_cycles, e.cyc);
            end
        end
    end

    initial begin
        rst = 1'b1;
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0;
        excp_valid = 1'b0;
        eret_valid = 1'b0;
        epc        = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        //   name        rst req      ex  er  epc  stall      fl  new_pc tmo cyc
        cyc("rst_hold",  1, 4'b1111, 0, 0, 0,  6'b000000, 0, 0,  0, 0);
        cyc("id_stall",  0, 4'b0010, 0, 0, 0,  6'b000111, 0, 0,  0, 0);
        cyc("id_off",    0, 4'b0000, 0, 0, 0,  6'b000000, 0, 0,  0, 1);
        cyc("all_req",   0, 4'b1111, 0, 0, 0,  6'b011111, 0, 0,  0, 1);
        cyc("drop_mem",  0, 4'b0111, 0, 0, 0,  6'b001111, 0, 0,  0, 2);
        cyc("if_only",   0, 4'b0001, 0, 0, 0,  6'b000011, 0, 0,  0, 3);
        cyc("idle",      0, 4'b0000, 0, 0, 0,  6'b000000, 0, 0,  0, 4);
        cyc("excp_N",    0, 4'b0000, 1, 0, 0,  6'b000000, 0, 0,  0, 4);
        cyc("excp_N1",   0, 4'b0000, 0, 0, 0,  6'b000000, 1, EV, 0, 4);
        cyc("excp_N2",   0, 4'b0000, 0, 0, 0,  6'b000000, 0, EV, 0, 4);
        cyc("both",      0, 4'b0000, 1, 1, RA, 6'b000000, 0, EV, 0, 4);
        cyc("both_fl",   0, 4'b0100, 0, 1, RA, 6'b000000, 1, EV, 0, 4);
        cyc("eret",      0, 4'b0000, 0, 1, RA, 6'b000000, 0, EV, 0, 4);
        cyc("eret_fl",   0, 4'b0000, 0, 0, 0,  6'b000000, 1, RA, 0, 4);
        cyc("excp_mem",  0, 4'b1000, 1, 0, 0,  6'b011111, 0, RA, 0, 4);
        cyc("no_flush",  0, 4'b0000, 0, 0, 0,  6'b000000, 0, RA, 0, 5);
        cyc("wd1",       0, 4'b0100, 0, 0, 0,  6'b001111, 0, RA, 0, 5);
        cyc("wd2",       0, 4'b0100, 0, 0, 0,  6'b001111, 0, RA, 0, 6);
        cyc("wd3",       0, 4'b0100, 0, 0, 0,  6'b001111, 0, RA, 0, 7);
        cyc("wd4",       0, 4'b0100, 0, 0, 0,  6'b001111, 0, RA, 0, 8);
        cyc("wd_trip",   0, 4'b0000, 0, 0, 0,  6'b000000, 0, RA, 1, 9);
        cyc("wd_sticky", 0, 4'b0000, 0, 0, 0,  6'b000000, 0, RA, 1, 9);
        cyc("rst_mid",   1, 4'b0100, 0, 0, 0,  6'b000000, 0, RA, 1, 9);
        cyc("rst_done",  0, 4'b0000, 0, 0, 0,  6'b000000, 0, 0,  0, 0);
        cyc("excp2",     0, 4'b0000, 1, 0, 0,  6'b000000, 0, 0,  0, 0);
        cyc("rst_in_fl", 1, 4'b0000, 0, 0, 0,  6'b000000, 0, EV, 0, 0);
        cyc("after_rst", 0, 4'b0000, 0, 0, 0,  6'b000000, 0, 0,  0, 0);
        for (int i = 0; i < 4 && sb.size() > 0; i++)
            @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
